// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronised rx, single mid-bit sample per bit,
// received byte held in rx_data with a level valid / ack handshake.
module uart_rx #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       framing_err,
    output logic       overrun,
    output logic       busy
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state, state_n;
    logic             rx_s1, rx_s2;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       idx, idx_n;
    logic [7:0]       shift, shift_n;
    logic [7:0]       data_n;
    logic             valid_n, ferr_n, ovr_n;

    // Synchroniser idles high so a line held low through reset release still
    // presents a falling edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            idx         <= '0;
            shift       <= '0;
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            shift       <= shift_n;
            rx_data     <= data_n;
            rx_valid    <= valid_n;
            framing_err <= ferr_n;
            overrun     <= ovr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shift_n = shift;
        data_n  = rx_data;
        valid_n = rx_valid;
        ferr_n  = 1'b0;
        ovr_n   = overrun;

        // An accepted ack is applied first so a byte landing in the same
        // cycle re-asserts valid without flagging an overrun.
        if (rx_ack && rx_valid) begin
            valid_n = 1'b0;
            ovr_n   = 1'b0;
        end

        case (state)
            S_IDLE: begin
                if (!rx_s2) begin
                    state_n = S_START;
                    cnt_n   = '0;
                end
            end
            S_START: begin
                if (cnt == CNT_HALF_END) begin
                    cnt_n = '0;
                    if (!rx_s2) begin
                        state_n = S_DATA;
                        idx_n   = '0;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt == CNT_BIT_END) begin
                    shift_n = {rx_s2, shift[7:1]};
                    cnt_n   = '0;
                    idx_n   = idx + 3'd1;
                    if (idx == 3'd7) begin
                        state_n = S_STOP;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt == CNT_BIT_END) begin
                    cnt_n = '0;
                    if (rx_s2) begin
                        data_n  = shift;
                        valid_n = 1'b1;
                        if (rx_valid && !rx_ack) begin
                            ovr_n = 1'b1;
                        end
                        state_n = S_IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = S_BREAK;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_BREAK: begin
                if (rx_s2) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected bytes, a monitor
// pops and compares whenever a new byte appears on rx_data/rx_valid.
module tb_uart_rx;

    localparam int CPB = 104;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       framing_err;
    logic       overrun;
    logic       busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ferr_cnt = 0;
    int exp_ferr = 0;
    int start_cyc = 0;
    int rise_cyc = 0;
    int ack_req = 0;
    int ack_done = 0;
    bit auto_ack = 1'b0;
    logic [7:0] exp_q[$];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ack     (rx_ack),
        .framing_err(framing_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_lvl);
        @(negedge clk);
        rx = 1'b0;
        start_cyc = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_lvl;
        repeat (CPB) @(negedge clk);
    endtask

    // Monitor: a new byte is a valid rise or a data change while valid.
    initial begin
        logic       pv;
        logic [7:0] pd;
        logic       pf;
        logic [7:0] e;
        pv = 1'b0;
        pd = 8'h00;
        pf = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && rx_valid && (!pv || rx_data != pd)) begin
                if (!pv) rise_cyc = cyc;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_byte act=%h exp=none (cycle %0d)", rx_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_data", {24'h0, rx_data}, {24'h0, e});
                end
            end
            if (framing_err) begin
                ferr_cnt++;
                check("ferr_one_cycle", {31'h0, pf}, 32'h0);
            end
            pv = rx_valid;
            pd = rx_data;
            pf = framing_err;
        end
    end

    // Acknowledge driver: automatic one cycle after a valid rise, or on request.
    initial begin
        forever begin
            @(negedge clk);
            if (rx_ack) begin
                rx_ack = 1'b0;
                check("valid_after_ack", {31'h0, rx_valid}, 32'h0);
                check("ovr_after_ack", {31'h0, overrun}, 32'h0);
            end else if (rst && rx_valid && (auto_ack || ack_req != ack_done)) begin
                rx_ack = 1'b1;
                if (!auto_ack) ack_done++;
            end
        end
    end

    initial begin
        int d;
        int g;
        logic [7:0] ab;

        rst = 1'b0;
        rx  = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_data", {24'h0, rx_data}, 32'h0);
        check("rst_valid", {31'h0, rx_valid}, 32'h0);
        check("rst_ferr", {31'h0, framing_err}, 32'h0);
        check("rst_ovr", {31'h0, overrun}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Test 1: 0xA5 with latency check
        auto_ack = 1'b1;
        exp_q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (500) @(negedge clk);
                check("t1_busy_mid", {31'h0, busy}, 32'h1);
            end
        join
        d = rise_cyc - start_cyc;
        total++;
        if (d < 990 || d > 992) begin
            bad++;
            $display("FAIL t1_latency act=%0d exp=990..992", d);
        end
        check("t1_busy_end", {31'h0, busy}, 32'h0);

        // Test 2: back-to-back 0x00, 0xFF
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        repeat (5) @(negedge clk);
        check("t2_data", {24'h0, rx_data}, 32'hFF);
        check("t2_valid", {31'h0, rx_valid}, 32'h0);
        check("t2_ovr", {31'h0, overrun}, 32'h0);

        // Test 3: 20-cycle glitch
        @(negedge clk);
        rx = 1'b0;
        g = cyc;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        check("t3_busy_high", {31'h0, busy}, 32'h1);
        repeat (30) @(negedge clk);
        check("t3_busy_low", {31'h0, busy}, 32'h0);
        check("t3_valid", {31'h0, rx_valid}, 32'h0);
        check("t3_ferr_cnt", ferr_cnt, 0);

        // Test 4: bad stop bit, held break, then recovery
        exp_ferr++;
        send_frame(8'h3C, 1'b0);
        repeat (500) @(negedge clk);
        check("t4_busy_break", {31'h0, busy}, 32'h1);
        check("t4_valid", {31'h0, rx_valid}, 32'h0);
        check("t4_ferr_cnt", ferr_cnt, 1);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        check("t4_busy_idle", {31'h0, busy}, 32'h0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        repeat (5) @(negedge clk);

        // Test 5: overrun
        auto_ack = 1'b0;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send_frame(8'h11, 1'b1);
        check("t5_valid1", {31'h0, rx_valid}, 32'h1);
        check("t5_ovr1", {31'h0, overrun}, 32'h0);
        send_frame(8'h22, 1'b1);
        check("t5_data2", {24'h0, rx_data}, 32'h22);
        check("t5_valid2", {31'h0, rx_valid}, 32'h1);
        check("t5_ovr2", {31'h0, overrun}, 32'h1);
        ack_req++;
        repeat (5) @(negedge clk);
        check("t5_valid_clr", {31'h0, rx_valid}, 32'h0);
        check("t5_ovr_clr", {31'h0, overrun}, 32'h0);

        // Test 6: reset mid-frame
        auto_ack = 1'b1;
        ab = 8'h96;
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = ab[i];
            repeat (CPB) @(negedge clk);
        end
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b0;
        rx  = 1'b1;
        repeat (5) @(negedge clk);
        check("t6_rst_data", {24'h0, rx_data}, 32'h0);
        check("t6_rst_valid", {31'h0, rx_valid}, 32'h0);
        check("t6_rst_ferr", {31'h0, framing_err}, 32'h0);
        check("t6_rst_ovr", {31'h0, overrun}, 32'h0);
        check("t6_rst_busy", {31'h0, busy}, 32'h0);
        rst = 1'b1;
        repeat (300) @(negedge clk);
        check("t6_no_partial", {31'h0, rx_valid}, 32'h0);
        exp_q.push_back(8'h69);
        send_frame(8'h69, 1'b1);
        repeat (5) @(negedge clk);
        check("t6_data", {24'h0, rx_data}, 32'h69);

        for (int k = 0; k < 2000 && exp_q.size() != 0; k++) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        check("ferr_total", ferr_cnt, exp_ferr);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver. It is the receive-side counterpart of uart_tx on the same serial link.
- Runs on the 12 MHz hfosc_clk domain.
- Synchronizes the asynchronous rx pin and samples each bit at mid-bit.
- Presents each received byte in a holding register with a valid/ack handshake to downstream logic (sample buffer / command parser).

Parameters:
- CLKS_PER_BIT, 104, clk cycles per bit (12 MHz / 115200 baud, rounded down). Minimum legal value 4.
- HALF_BIT, CLKS_PER_BIT/2 (integer divide), derived, cycles from detected start edge to start-bit mid-point sample.

Ports:
- clk  input  1  system clock, hfosc_clk, 12 MHz
- rst  input  1  asynchronous, active-low reset
- rx  input  1  serial line, idle high, asynchronous to clk
- rx_data  output  8  last correctly framed byte; LSB is the first bit received
- rx_valid  output  1  level; high while rx_data holds an unconsumed byte
- rx_ack  input  1  consumer acknowledge, sampled each clk; clears rx_valid
- framing_err  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  sticky: a byte was overwritten while rx_valid was high
- busy  output  1  high whenever FSM state is not IDLE

Behaviour:
- Reset (rst low, async):
  - state=IDLE; bit counter, bit index and shift register=0.
  - Two-flop synchronizer rx_s1/rx_s2 forced to 1.
  - rx_data=8'h00, rx_valid=0, framing_err=0, overrun=0, busy=0.
- All FSM decisions use rx_s2, which is rx delayed 2 clk.
- IDLE: when rx_s2==0, go to START with cnt=0.
- START:
  - cnt increments each cycle.
  - At cnt==HALF_BIT-1, sample rx_s2.
  - Sample 0: go to DATA with cnt=0, idx=0.
  - Sample 1: the low was a glitch; return to IDLE with no output and no error.
- DATA:
  - At cnt==CLKS_PER_BIT-1, shift rx_s2 in at MSB (shift right), set cnt=0, idx++.
  - After the 8th sample (idx==7 at sample time), go to STOP.
- STOP: at cnt==CLKS_PER_BIT-1, sample rx_s2.
  - Sample 1: rx_data<=shift reg; rx_valid<=1; go to IDLE.
  - Sample 0: framing_err=1 for exactly one cycle; rx_data and rx_valid unchanged; go to BREAK.
- BREAK: stay until rx_s2==1, then go to IDLE. A held-low line never produces repeated bytes or errors.
- Handshake:
  - rx_ack while rx_valid=1: rx_valid<=0 next cycle.
  - rx_ack while rx_valid=0: ignored.
  - rx_data stays stable while rx_valid=1 unless an overrun occurs.
- Byte completes while rx_valid=1 and rx_ack=0 in that cycle:
  - rx_data is overwritten; rx_valid stays 1; overrun<=1.
  - overrun stays set until an rx_ack is accepted; it clears on the same edge as rx_valid.
- Byte completes in the same cycle rx_ack=1: the new byte loads, rx_valid stays 1, no overrun.
- Latency: rx_valid rises exactly 2 + HALF_BIT + 9*CLKS_PER_BIT + 1 clk after the rx falling edge of the start bit, ±1 clk for synchronizer phase.
- Bit sampling happens once per bit at the counted mid-point; no oversampling vote.
- Reset mid-frame: all state is abandoned immediately and no partial byte is output. After release, the block waits for rx_s2 high→low before accepting a new frame. A line still low at release enters START; if that low persists, it is rejected only by framing in STOP→BREAK.
- busy is a combinational decode of state and is 0 only in IDLE.

Test Plan:
1. Reset, rx=1 idle, then send byte 0xA5 at CLKS_PER_BIT=104. Required: rx_valid rises within ±1 clk of 2+52+936+1 cycles after the start edge; rx_data=0xA5; framing_err never pulses; busy high for the frame duration.
2. Send 0x00 then 0xFF back-to-back, pulsing rx_ack one cycle after each rx_valid rise. Required: rx_data=0x00 then 0xFF; rx_valid falls the cycle after each ack; overrun stays 0.
3. Drive a 20-cycle low glitch on idle rx. Required: FSM returns to IDLE after the start-bit mid sample; rx_valid=0; framing_err=0; busy high ~52 cycles then low.
4. Send 0x3C with the stop bit driven 0, then hold rx low 500 cycles, then release high. Required: single framing_err pulse; rx_valid stays 0; busy stays high until rx returns high; the next valid frame 0x5A is received correctly.
5. Send 0x11 then 0x22 with no rx_ack. Required: after the second frame rx_data=0x22, rx_valid=1, overrun=1. A single rx_ack then clears both rx_valid and overrun.
6. Assert rst low mid-way through the DATA bits of 0x96, release, then send 0x69. Required: all outputs at reset values while rst=0; no byte from the aborted frame; 0x69 is received with rx_valid=1.
